// File: rtl/perceptron_trainer.sv
// Perceptron predictor training stage: decides whether a resolved branch needs
// training and streams saturating row updates plus one bias update to memory.
module perceptron_trainer #(
  parameter int unsigned NUM_TABLES                   = 4,
  parameter int unsigned PERCEPTRON_TABLE_NUM_ENTRIES = 256,
  parameter int unsigned PERCEPTRON_NUM_WEIGHTS       = 8,
  parameter int unsigned PERCEPTRON_WEIGHT_WIDTH      = 8,
  parameter int unsigned BIAS_TABLE_NUM_ENTRIES       = 256,
  parameter int unsigned BIAS_WEIGHT_WIDTH            = 8,
  parameter int unsigned SUM_WIDTH                    = 16,
  parameter int unsigned THETA                        = 30,
  localparam int unsigned IDX_W   = (NUM_TABLES > 1) ? $clog2(NUM_TABLES) : 1,
  localparam int unsigned ADDR_W  = $clog2(PERCEPTRON_TABLE_NUM_ENTRIES),
  localparam int unsigned BADDR_W = $clog2(BIAS_TABLE_NUM_ENTRIES),
  localparam int unsigned NW      = PERCEPTRON_NUM_WEIGHTS,
  localparam int unsigned WW      = PERCEPTRON_WEIGHT_WIDTH,
  localparam int unsigned BW      = BIAS_WEIGHT_WIDTH,
  localparam int unsigned ROW_W   = NW * WW
) (
  input  logic                           clk,
  input  logic                           rst,
  input  logic                           train_valid,
  output logic                           train_ready,
  input  logic                           train_taken,
  input  logic [SUM_WIDTH-1:0]           train_sum,
  input  logic [NUM_TABLES*NW-1:0]       train_history,
  input  logic [NUM_TABLES*ADDR_W-1:0]   train_addrs,
  input  logic [NUM_TABLES*ROW_W-1:0]    train_weights,
  input  logic [BADDR_W-1:0]             train_bias_addr,
  input  logic [BW-1:0]                  train_bias,
  output logic                           write_enable,
  output logic [IDX_W-1:0]               write_table_idx,
  output logic [ADDR_W-1:0]              write_addr,
  output logic [ROW_W-1:0]               write_data,
  output logic                           bias_write_enable,
  output logic [BADDR_W-1:0]             bias_write_addr,
  output logic [BW-1:0]                  bias_write_data,
  output logic [31:0]                    train_count
);

  typedef enum logic {IDLE, UPDATE} state_t;

  localparam logic [WW-1:0]    W_MAX    = {1'b0, {(WW-1){1'b1}}};
  localparam logic [WW-1:0]    W_MIN    = {1'b1, {(WW-1){1'b0}}};
  localparam logic [BW-1:0]    B_MAX    = {1'b0, {(BW-1){1'b1}}};
  localparam logic [BW-1:0]    B_MIN    = {1'b1, {(BW-1){1'b0}}};
  localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(NUM_TABLES - 1);

  function automatic logic [WW-1:0] step_weight(input logic [WW-1:0] w, input logic up);
    if (up) return (w == W_MAX) ? w : w + WW'(1);
    else    return (w == W_MIN) ? w : w - WW'(1);
  endfunction

  function automatic logic [BW-1:0] step_bias(input logic [BW-1:0] b, input logic up);
    if (up) return (b == B_MAX) ? b : b + BW'(1);
    else    return (b == B_MIN) ? b : b - BW'(1);
  endfunction

  state_t state, state_d;
  logic [IDX_W-1:0] idx, idx_d;

  // Snapshot of the accepted request
  logic                         cap_taken;
  logic [NUM_TABLES*NW-1:0]     cap_history;
  logic [NUM_TABLES*ADDR_W-1:0] cap_addrs;
  logic [NUM_TABLES*ROW_W-1:0]  cap_weights;
  logic [BADDR_W-1:0]           cap_bias_addr;
  logic [BW-1:0]                cap_bias;

  logic                         sum_neg;
  logic [SUM_WIDTH:0]           sum_ext;
  logic [SUM_WIDTH:0]           sum_abs;
  logic                         need_train;
  logic                         accept;

  logic                         src_taken;
  logic [NUM_TABLES*NW-1:0]     src_history;
  logic [NUM_TABLES*ADDR_W-1:0] src_addrs;
  logic [NUM_TABLES*ROW_W-1:0]  src_weights;
  logic [BADDR_W-1:0]           src_bias_addr;
  logic [BW-1:0]                src_bias;

  logic                         ready_d;
  logic                         we_d;
  logic [IDX_W-1:0]             tbl_d;
  logic [ADDR_W-1:0]            addr_d;
  logic [ROW_W-1:0]             data_d;
  logic                         bias_we_d;
  logic [BADDR_W-1:0]           bias_addr_d;
  logic [BW-1:0]                bias_data_d;
  logic [31:0]                  count_d;

  // Training decision; magnitude is one bit wider so the most-negative sum fits
  always_comb begin
    sum_neg    = train_sum[SUM_WIDTH-1];
    sum_ext    = {sum_neg, train_sum};
    sum_abs    = sum_neg ? (~sum_ext + (SUM_WIDTH+1)'(1)) : sum_ext;
    need_train = ((!sum_neg) != train_taken) || (sum_abs <= (SUM_WIDTH+1)'(THETA));
    accept     = train_valid && (state == IDLE);
  end

  // On the accept edge the first writes come straight from the request inputs
  always_comb begin
    src_taken     = accept ? train_taken     : cap_taken;
    src_history   = accept ? train_history   : cap_history;
    src_addrs     = accept ? train_addrs     : cap_addrs;
    src_weights   = accept ? train_weights   : cap_weights;
    src_bias_addr = accept ? train_bias_addr : cap_bias_addr;
    src_bias      = accept ? train_bias      : cap_bias;
  end

  // Next-state and next-output logic
  always_comb begin
    state_d     = state;
    idx_d       = idx;
    we_d        = 1'b0;
    tbl_d       = write_table_idx;
    addr_d      = write_addr;
    data_d      = write_data;
    bias_we_d   = 1'b0;
    bias_addr_d = bias_write_addr;
    bias_data_d = bias_write_data;
    count_d     = train_count;

    unique case (state)
      IDLE: begin
        if (accept && need_train) begin
          state_d = UPDATE;
          idx_d   = '0;
          count_d = train_count + 32'd1;
        end
      end
      UPDATE: begin
        if (idx == IDX_LAST) begin
          state_d = IDLE;
          idx_d   = '0;
        end else begin
          idx_d = idx + IDX_W'(1);
        end
      end
      default: begin
        state_d = IDLE;
        idx_d   = '0;
      end
    endcase

    if (state_d == UPDATE) begin
      we_d  = 1'b1;
      tbl_d = idx_d;
      for (int i = 0; i < int'(NUM_TABLES); i++) begin
        if (idx_d == IDX_W'(i)) begin
          addr_d = src_addrs[i*ADDR_W +: ADDR_W];
          for (int j = 0; j < int'(NW); j++) begin
            data_d[j*WW +: WW] = step_weight(src_weights[(i*NW+j)*WW +: WW],
                                             src_history[i*NW+j] == src_taken);
          end
        end
      end
    end

    if ((state == IDLE) && (state_d == UPDATE)) begin
      bias_we_d   = 1'b1;
      bias_addr_d = src_bias_addr;
      bias_data_d = step_bias(src_bias, src_taken);
    end

    ready_d = (state_d == IDLE);
  end

  // State, snapshot and registered outputs
  always_ff @(posedge clk) begin
    if (rst) begin
      state             <= IDLE;
      idx               <= '0;
      cap_taken         <= 1'b0;
      cap_history       <= '0;
      cap_addrs         <= '0;
      cap_weights       <= '0;
      cap_bias_addr     <= '0;
      cap_bias          <= '0;
      train_ready       <= 1'b1;
      write_enable      <= 1'b0;
      write_table_idx   <= '0;
      write_addr        <= '0;
      write_data        <= '0;
      bias_write_enable <= 1'b0;
      bias_write_addr   <= '0;
      bias_write_data   <= '0;
      train_count       <= '0;
    end else begin
      state             <= state_d;
      idx               <= idx_d;
      if (accept) begin
        cap_taken     <= train_taken;
        cap_history   <= train_history;
        cap_addrs     <= train_addrs;
        cap_weights   <= train_weights;
        cap_bias_addr <= train_bias_addr;
        cap_bias      <= train_bias;
      end
      train_ready       <= ready_d;
      write_enable      <= we_d;
      write_table_idx   <= tbl_d;
      write_addr        <= addr_d;
      write_data        <= data_d;
      bias_write_enable <= bias_we_d;
      bias_write_addr   <= bias_addr_d;
      bias_write_data   <= bias_data_d;
      train_count       <= count_d;
    end
  end

endmodule

// File: tb/tb_perceptron_trainer.sv
// Directed bench for perceptron_trainer with hand-computed expected writes.
module tb_perceptron_trainer;

  logic         clk = 1'b0;
  logic         rst;
  logic         train_valid;
  logic         train_ready;
  logic         train_taken;
  logic [15:0]  train_sum;
  logic [31:0]  train_history;
  logic [31:0]  train_addrs;
  logic [255:0] train_weights;
  logic [7:0]   train_bias_addr;
  logic [7:0]   train_bias;
  logic         write_enable;
  logic [1:0]   write_table_idx;
  logic [7:0]   write_addr;
  logic [63:0]  write_data;
  logic         bias_write_enable;
  logic [7:0]   bias_write_addr;
  logic [7:0]   bias_write_data;
  logic [31:0]  train_count;

  int n_checks = 0;
  int n_fail   = 0;

  logic [7:0] exp_addr [4];

  perceptron_trainer dut (
    .clk               (clk),
    .rst               (rst),
    .train_valid       (train_valid),
    .train_ready       (train_ready),
    .train_taken       (train_taken),
    .train_sum         (train_sum),
    .train_history     (train_history),
    .train_addrs       (train_addrs),
    .train_weights     (train_weights),
    .train_bias_addr   (train_bias_addr),
    .train_bias        (train_bias),
    .write_enable      (write_enable),
    .write_table_idx   (write_table_idx),
    .write_addr        (write_addr),
    .write_data        (write_data),
    .bias_write_enable (bias_write_enable),
    .bias_write_addr   (bias_write_addr),
    .bias_write_data   (bias_write_data),
    .train_count       (train_count)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // Present one request for a single accept edge; returns #1 into cycle 1
  task automatic request(input logic [15:0] sum, input logic taken, input logic [31:0] hist,
                         input logic [255:0] w, input logic [7:0] b);
    train_sum     = sum;
    train_taken   = taken;
    train_history = hist;
    train_weights = w;
    train_bias    = b;
    train_valid   = 1'b1;
    @(posedge clk);
    #1;
    train_valid = 1'b0;
  endtask

  task automatic expect_update(input string name, input logic [255:0] rows, input logic [7:0] bexp);
    for (int k = 0; k < 4; k++) begin
      check($sformatf("%s we[%0d]", name, k), 64'(write_enable), 64'd1);
      check($sformatf("%s tbl[%0d]", name, k), 64'(write_table_idx), 64'(k));
      check($sformatf("%s addr[%0d]", name, k), 64'(write_addr), 64'(exp_addr[k]));
      check($sformatf("%s data[%0d]", name, k), write_data, rows[k*64 +: 64]);
      check($sformatf("%s bias_we[%0d]", name, k), 64'(bias_write_enable), 64'(k == 0));
      check($sformatf("%s ready[%0d]", name, k), 64'(train_ready), 64'd0);
      if (k == 0) begin
        check($sformatf("%s bias_addr", name), 64'(bias_write_addr), 64'h5A);
        check($sformatf("%s bias_data", name), 64'(bias_write_data), 64'(bexp));
      end
      @(posedge clk);
      #1;
    end
    check($sformatf("%s we_after", name), 64'(write_enable), 64'd0);
    check($sformatf("%s ready_after", name), 64'(train_ready), 64'd1);
  endtask

  task automatic expect_no_train(input string name, input logic [31:0] cnt);
    check($sformatf("%s we", name), 64'(write_enable), 64'd0);
    check($sformatf("%s bias_we", name), 64'(bias_write_enable), 64'd0);
    check($sformatf("%s ready", name), 64'(train_ready), 64'd1);
    check($sformatf("%s count", name), 64'(train_count), 64'(cnt));
  endtask

  initial begin
    int acc_cyc [3];
    int acc;
    int we_cycles;
    int overlap;

    exp_addr[0] = 8'h11; exp_addr[1] = 8'h22; exp_addr[2] = 8'h33; exp_addr[3] = 8'h44;
    rst             = 1'b1;
    train_valid     = 1'b0;
    train_taken     = 1'b0;
    train_sum       = '0;
    train_history   = '0;
    train_addrs     = {8'h44, 8'h33, 8'h22, 8'h11};
    train_weights   = '0;
    train_bias_addr = 8'h5A;
    train_bias      = '0;
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;

    check("reset ready", 64'(train_ready), 64'd1);
    check("reset we", 64'(write_enable), 64'd0);
    check("reset bias_we", 64'(bias_write_enable), 64'd0);
    check("reset count", 64'(train_count), 64'd0);

    // Mispredict: weights 0 -> +1 everywhere
    request(16'hFFFB, 1'b1, 32'hFFFF_FFFF, '0, 8'h00);
    expect_update("mispredict", {4{64'h0101_0101_0101_0101}}, 8'h01);
    check("mispredict count", 64'(train_count), 64'd1);

    // Confident correct prediction
    request(16'd100, 1'b1, 32'hFFFF_FFFF, '0, 8'h00);
    expect_no_train("confident", 32'd1);

    // |sum| == THETA trains; mixed history around weight 5
    request(16'd30, 1'b1, 32'hA5A5_A5A5, {32{8'h05}}, 8'h05);
    expect_update("theta30", {4{64'h0604_0604_0406_0406}}, 8'h06);
    check("theta30 count", 64'(train_count), 64'd2);

    request(16'd31, 1'b1, 32'hFFFF_FFFF, '0, 8'h00);
    expect_no_train("theta31", 32'd2);

    // sum = -30, not taken: correct but within threshold
    request(16'hFFE2, 1'b0, 32'h0000_0000, {32{8'hFD}}, 8'h00);
    expect_update("neg30", {4{64'hFEFE_FEFE_FEFE_FEFE}}, 8'hFF);
    check("neg30 count", 64'(train_count), 64'd3);

    // Saturation at both limits
    request(16'hFFFF, 1'b1, {8'h00, 8'hFF, 8'h00, 8'hFF},
            {{8{8'h80}}, {8{8'h7F}}, {8{8'h80}}, {8{8'h7F}}}, 8'h7F);
    expect_update("saturate", {{8{8'h80}}, {8{8'h7F}}, {8{8'h80}}, {8{8'h7F}}}, 8'h7F);
    check("saturate count", 64'(train_count), 64'd4);

    // Back-to-back training requests with valid held high
    train_sum     = 16'hFFFB;
    train_taken   = 1'b1;
    train_history = 32'hFFFF_FFFF;
    train_weights = '0;
    train_bias    = 8'h00;
    train_valid   = 1'b1;
    acc = 0; we_cycles = 0; overlap = 0;
    acc_cyc[0] = -1; acc_cyc[1] = -1; acc_cyc[2] = -1;
    for (int c = 0; c < 16; c++) begin
      if (train_valid && train_ready && acc < 3) begin
        acc_cyc[acc] = c;
        acc++;
      end
      @(posedge clk);
      #1;
      if (acc == 3) train_valid = 1'b0;
      if (write_enable) we_cycles++;
      if (write_enable && train_ready) overlap++;
    end
    train_valid = 1'b0;
    check("b2b accept0", 64'(acc_cyc[0]), 64'd0);
    check("b2b accept1", 64'(acc_cyc[1]), 64'd5);
    check("b2b accept2", 64'(acc_cyc[2]), 64'd10);
    check("b2b write cycles", 64'(we_cycles), 64'd12);
    check("b2b overlap", 64'(overlap), 64'd0);
    check("b2b count", 64'(train_count), 64'd7);

    // Reset in the middle of an update
    request(16'hFFFB, 1'b1, 32'hFFFF_FFFF, '0, 8'h00);
    check("rst cyc1 we", 64'(write_enable), 64'd1);
    check("rst cyc1 tbl", 64'(write_table_idx), 64'd0);
    @(posedge clk);
    #1;
    check("rst cyc2 tbl", 64'(write_table_idx), 64'd1);
    rst = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
    check("rst cyc3 we", 64'(write_enable), 64'd0);
    check("rst cyc3 bias_we", 64'(bias_write_enable), 64'd0);
    check("rst cyc3 ready", 64'(train_ready), 64'd1);
    check("rst cyc3 count", 64'(train_count), 64'd0);
    @(posedge clk);
    #1;
    check("rst cyc4 we", 64'(write_enable), 64'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
